// File: rtl/tick_divider.sv
// tick_divider
// ------------
// Runtime-programmable clock-enable generator. Every eff enabled clocks it
// emits a one-cycle TICK strobe, where eff = max(div_act, 1). SQ toggles on
// each tick, which gives a square wave of period 2*eff. TCOUNT counts the
// ticks and wraps modulo 2^CNT_W.
//
// A new divisor is captured into a shadow register by DIV_LOAD. It is
// swapped in only at the next terminal count, so no period is ever cut
// short or stretched. SYNC restarts the phase at once and applies the
// newest divisor immediately.
//
// All outputs are registered, so there is no combinational path from the
// inputs to TICK, SQ, TCOUNT or DIV_CUR.
//
// Ports:
//   CLK      in   system clock
//   RST      in   asynchronous active-high reset
//   EN       in   count enable; low freezes the phase accumulator
//   DIV_IN   in   [WIDTH]  divisor value captured by DIV_LOAD
//   DIV_LOAD in   strobe: DIV_IN -> shadow, marks a swap as pending
//   SYNC     in   strobe: restart phase, apply the newest divisor now
//   TICK     out  one-cycle strobe at each terminal count
//   SQ       out  square wave, toggles on every tick, cleared by SYNC
//   TCOUNT   out  [CNT_W]  ticks emitted, modulo 2^CNT_W
//   DIV_CUR  out  [WIDTH]  divisor in effect (raw value, 0 allowed)
`timescale 1ns/1ps
module tick_divider #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 4194305,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV_IN,
  input  logic             DIV_LOAD,
  input  logic             SYNC,
  output logic             TICK,
  output logic             SQ,
  output logic [CNT_W-1:0] TCOUNT,
  output logic [WIDTH-1:0] DIV_CUR
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q,   pend_d;
  logic             tick_q,   tick_d;
  logic             sq_q,     sq_d;
  logic [CNT_W-1:0] tcount_q, tcount_d;

  logic [WIDTH-1:0] eff;
  logic             terminal;

  // A divisor of zero behaves as one, so the counter can never stall.
  assign eff      = (div_act_q == '0) ? ONE : div_act_q;
  assign terminal = (acc_q == (eff - ONE));

  always_comb begin
    acc_d     = acc_q;
    div_act_d = div_act_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;
    tcount_d  = tcount_q;

    if (SYNC) begin
      // SYNC beats EN and any coincident terminal count: no tick this cycle.
      acc_d  = '0;
      sq_d   = 1'b0;
      pend_d = 1'b0;
      if (DIV_LOAD) begin
        div_act_d = DIV_IN;
        shadow_d  = DIV_IN;
      end else if (pend_q) begin
        div_act_d = shadow_q;
      end
    end else begin
      if (EN) begin
        if (terminal) begin
          acc_d    = '0;
          tick_d   = 1'b1;
          sq_d     = ~sq_q;
          tcount_d = tcount_q + CNT_W'(1);
          // The swap uses the pending state from before this edge; a load
          // arriving on this same edge waits for the following terminal count.
          if (pend_q) begin
            div_act_d = shadow_q;
            pend_d    = 1'b0;
          end
        end else begin
          acc_d = acc_q + ONE;
        end
      end
      if (DIV_LOAD) begin
        shadow_d = DIV_IN;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q     <= '0;
      div_act_q <= DEF_DIV;
      shadow_q  <= DEF_DIV;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
      tcount_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      tcount_q  <= tcount_d;
    end
  end

  assign TICK    = tick_q;
  assign SQ      = sq_q;
  assign TCOUNT  = tcount_q;
  assign DIV_CUR = div_act_q;

endmodule

// File: tb/tb_tick_divider.sv
// Testbench for tick_divider (WIDTH=8, DEFAULT_DIV=4, CNT_W=5).
// A behavioural model counts the enabled cycles into the current period and
// pushes the expected outputs into exp_q on each rising edge. The compare
// process pops one entry on each falling edge. Directed sequences add
// hand-computed literal checks on top of that.
`timescale 1ns/1ps
module tb_tick_divider;

  localparam int WIDTH = 8;
  localparam int CNT_W = 5;
  localparam int DEF   = 4;
  localparam int W     = 2 + CNT_W + WIDTH;

  logic             CLK      = 1'b0;
  logic             RST      = 1'b0;
  logic             EN       = 1'b0;
  logic [WIDTH-1:0] DIV_IN   = '0;
  logic             DIV_LOAD = 1'b0;
  logic             SYNC     = 1'b0;
  logic             TICK;
  logic             SQ;
  logic [CNT_W-1:0] TCOUNT;
  logic [WIDTH-1:0] DIV_CUR;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  tick_divider #(
    .WIDTH(WIDTH),
    .DEFAULT_DIV(DEF),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .DIV_IN(DIV_IN),
    .DIV_LOAD(DIV_LOAD),
    .SYNC(SYNC),
    .TICK(TICK),
    .SQ(SQ),
    .TCOUNT(TCOUNT),
    .DIV_CUR(DIV_CUR)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_div    = DEF;
  int m_shadow = DEF;
  int m_phase  = 0;   // enabled cycles counted into the current period
  int m_ticks  = 0;   // total ticks since reset
  bit m_pend   = 1'b0;
  bit m_sq     = 1'b0;
  bit m_tick   = 1'b0;

  always @(posedge CLK or posedge RST) begin
    int eff;
    if (RST) begin
      m_div = DEF; m_shadow = DEF; m_pend = 1'b0;
      m_phase = 0; m_ticks = 0; m_sq = 1'b0; m_tick = 1'b0;
      exp_q.delete();
    end else begin
      if (SYNC) begin
        if (DIV_LOAD) begin
          m_div = int'(DIV_IN); m_shadow = int'(DIV_IN);
        end else if (m_pend) begin
          m_div = m_shadow;
        end
        m_pend = 1'b0; m_phase = 0; m_sq = 1'b0; m_tick = 1'b0;
      end else begin
        eff = (m_div == 0) ? 1 : m_div;
        m_tick = 1'b0;
        if (EN) begin
          m_phase++;
          if (m_phase == eff) begin
            m_tick = 1'b1;
            m_phase = 0;
            m_sq = !m_sq;
            m_ticks++;
            if (m_pend) begin
              m_div = m_shadow;
              m_pend = 1'b0;
            end
          end
        end
        if (DIV_LOAD) begin
          m_shadow = int'(DIV_IN);
          m_pend = 1'b1;
        end
      end
      exp_q.push_back({m_tick, m_sq, CNT_W'(m_ticks % (1 << CNT_W)), WIDTH'(m_div)});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    logic [W-1:0] e;
    if (RST) begin
      check("rst_tick",   32'(TICK),    32'(0));
      check("rst_sq",     32'(SQ),      32'(0));
      check("rst_tcount", 32'(TCOUNT),  32'(0));
      check("rst_divcur", 32'(DIV_CUR), 32'(DEF));
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_tick",   32'(TICK),    32'(e[W-1]));
      check("sb_sq",     32'(SQ),      32'(e[W-2]));
      check("sb_tcount", 32'(TCOUNT),  32'(e[WIDTH+CNT_W-1:WIDTH]));
      check("sb_divcur", 32'(DIV_CUR), 32'(e[WIDTH-1:0]));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    #1 RST = 1'b1;
    EN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Default divisor 4: ticks on cycles 4, 8, 12; SQ 1,0,1.
    for (int c = 1; c <= 12; c++) begin
      step();
      check("t1_tick", 32'(TICK), 32'((c % 4) == 0));
      if ((c % 4) == 0) check("t1_sq", 32'(SQ), 32'((c / 4) % 2));
    end
    check("t1_tcount", 32'(TCOUNT),  32'(3));
    check("t1_divcur", 32'(DIV_CUR), 32'(4));

    // Load 2 while acc=1: this period stays 4, then ticks every 2.
    step();
    DIV_IN = 8'd2; DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    check("t2_tick14", 32'(TICK), 32'(0));
    step();
    check("t2_tick15", 32'(TICK), 32'(0));
    check("t2_div15",  32'(DIV_CUR), 32'(4));
    step();
    check("t2_tick16", 32'(TICK), 32'(1));
    check("t2_div16",  32'(DIV_CUR), 32'(2));
    step(); check("t2_tick17", 32'(TICK), 32'(0));
    step(); check("t2_tick18", 32'(TICK), 32'(1));
    step(); check("t2_tick19", 32'(TICK), 32'(0));
    step(); check("t2_tick20", 32'(TICK), 32'(1));
    check("t2_tcount", 32'(TCOUNT), 32'(6));

    // Divisor 0 via load then SYNC: tick every cycle, TCOUNT wraps.
    DIV_IN = 8'd0; DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0; SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    check("t3_sync_tick", 32'(TICK),    32'(0));
    check("t3_sync_sq",   32'(SQ),      32'(0));
    check("t3_sync_div",  32'(DIV_CUR), 32'(0));
    check("t3_sync_tcnt", 32'(TCOUNT),  32'(6));
    for (int k = 1; k <= 26; k++) begin
      step();
      check("t3_tick",   32'(TICK),   32'(1));
      check("t3_sq",     32'(SQ),     32'(k % 2));
      check("t3_tcount", 32'(TCOUNT), 32'((6 + k) % 32));
      if (k == 25) check("t3_tcount31", 32'(TCOUNT), 32'(31));
    end
    check("t3_wrap0", 32'(TCOUNT), 32'(0));

    // Divisor 5 applied by SYNC+LOAD; EN gap of 7 cycles after 3 enabled.
    DIV_IN = 8'd5; DIV_LOAD = 1'b1; SYNC = 1'b1;
    step();
    DIV_LOAD = 1'b0; SYNC = 1'b0;
    check("t4_div",  32'(DIV_CUR), 32'(5));
    check("t4_tick", 32'(TICK),    32'(0));
    repeat (3) begin step(); check("t4_pre", 32'(TICK), 32'(0)); end
    EN = 1'b0;
    repeat (7) begin step(); check("t4_gap", 32'(TICK), 32'(0)); end
    EN = 1'b1;
    step(); check("t4_post1", 32'(TICK), 32'(0));
    step(); check("t4_post2", 32'(TICK), 32'(1));
    check("t4_sq",     32'(SQ),     32'(1));
    check("t4_tcount", 32'(TCOUNT), 32'(1));

    // SYNC + LOAD 3 on a terminal-count cycle: no tick, next tick 3 later.
    repeat (4) begin step(); check("t5_pre", 32'(TICK), 32'(0)); end
    SYNC = 1'b1; DIV_LOAD = 1'b1; DIV_IN = 8'd3;
    step();
    SYNC = 1'b0; DIV_LOAD = 1'b0;
    check("t5_tick",   32'(TICK),    32'(0));
    check("t5_sq",     32'(SQ),      32'(0));
    check("t5_div",    32'(DIV_CUR), 32'(3));
    check("t5_tcount", 32'(TCOUNT),  32'(1));
    step(); check("t5_c1", 32'(TICK), 32'(0));
    step(); check("t5_c2", 32'(TICK), 32'(0));
    step(); check("t5_c3", 32'(TICK), 32'(1));
    check("t5_sq3",     32'(SQ),     32'(1));
    check("t5_tcount3", 32'(TCOUNT), 32'(2));

    // Async reset mid-period with a divisor pending: pending value is lost.
    DIV_IN = 8'd7; DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    step();
    check("t6_pre_sq", 32'(SQ), 32'(1));
    #2 RST = 1'b1;
    #1;
    check("t6_tick",   32'(TICK),    32'(0));
    check("t6_sq",     32'(SQ),      32'(0));
    check("t6_tcount", 32'(TCOUNT),  32'(0));
    check("t6_div",    32'(DIV_CUR), 32'(DEF));
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check("t6_tick_after", 32'(TICK), 32'((c % 4) == 0));
    end
    check("t6_div_after", 32'(DIV_CUR), 32'(4));
    check("t6_tcount2",   32'(TCOUNT),  32'(2));

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
